// File: rtl/ext_mem_resp.sv
// ext_mem_resp: 2^ADDR_BITS x 32-bit memory model with independent read and write FSMs.
// Latency: wbvld at data-transfer cycle + LATENCY + 2; rdrdy first high at addr-transfer cycle + LATENCY + 2.
// Backpressure: one access in flight per direction; rdata/rdrdy hold while rden low. Optional EXT_MEM_CLEAR_EN zero-sweep.
module ext_mem_resp #(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        waen,
    input  logic [31:0] waddr,
    output logic        wardy,
    input  logic        wden,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic        wdrdy,
    output logic        wbvld,
    input  logic        raen,
    input  logic [31:0] raddr,
    output logic        rardy,
    input  logic        rden,
    output logic [31:0] rdata,
    output logic        rdrdy,
    output logic        init_done
);
    localparam int         DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    logic [31:0] mem [DEPTH];

    wstate_t              wst_q, wst_d;
    logic [3:0]           wcnt_q, wcnt_d;
    logic [ADDR_BITS-1:0] widx_q, widx_d;
    rstate_t              rst_q, rst_d;
    logic [3:0]           rcnt_q, rcnt_d;
    logic [ADDR_BITS-1:0] ridx_q, ridx_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 init_done_q, init_done_d;

    logic                 commit;
    logic [31:0]          rd_word;

    // Only the word-index bits of the addresses matter; the rest wrap away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{waddr[31:ADDR_BITS+2], waddr[1:0],
                                raddr[31:ADDR_BITS+2], raddr[1:0]};

    // A write commits on the edge that completes the data transfer.
    assign commit = (wst_q == W_DATA) && wden;

`ifdef EXT_MEM_CLEAR_EN
    logic [ADDR_BITS-1:0] clr_idx_q, clr_idx_d;
    logic                 clr_busy_q, clr_busy_d;

    // Zero one word per cycle after reset; init_done follows the last word.
    always_comb begin
        clr_idx_d   = clr_idx_q;
        clr_busy_d  = clr_busy_q;
        init_done_d = init_done_q;
        if (clr_busy_q) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == '1) begin
                clr_busy_d  = 1'b0;
                init_done_d = 1'b1;
            end
        end
    end

    // Sweep state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clr_idx_q  <= '0;
            clr_busy_q <= 1'b1;
        end else begin
            clr_idx_q  <= clr_idx_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    // Storage array: sweep zeroing has priority, writes cannot occur before init_done anyway.
    always_ff @(posedge clock) begin
        if (clr_busy_q) begin
            mem[clr_idx_q] <= '0;
        end else if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem[widx_q][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end
`else
    // Without the sweep the memory is usable from the first edge after reset.
    always_comb begin
        init_done_d = 1'b1;
    end

    // Storage array: byte-masked writes only, contents survive reset.
    always_ff @(posedge clock) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem[widx_q][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end
`endif

    // Write FSM next state: address, then data, then LATENCY+1 wait cycles, then response pulse.
    always_comb begin
        wst_d  = wst_q;
        wcnt_d = wcnt_q;
        widx_d = widx_q;
        case (wst_q)
            W_IDLE: begin
                if (waen && init_done_q) begin
                    widx_d = waddr[ADDR_BITS+1:2];
                    wst_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (wden) begin
                    wcnt_d = LAT;
                    wst_d  = W_WAIT;
                end
            end
            W_WAIT: begin
                if (wcnt_q == '0) wst_d = W_RESP;
                else              wcnt_d = wcnt_q - 4'd1;
            end
            default: wst_d = W_IDLE;
        endcase
    end

    // Read word with same-edge write bytes bypassed in, so a colliding read sees the new data.
    always_comb begin
        rd_word = mem[ridx_q];
        if (commit && (widx_q == ridx_q)) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) rd_word[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    // Read FSM next state: address, LATENCY+1 wait cycles ending in the rdata load, then hold until rden.
    always_comb begin
        rst_d   = rst_q;
        rcnt_d  = rcnt_q;
        ridx_d  = ridx_q;
        rdata_d = rdata_q;
        case (rst_q)
            R_IDLE: begin
                if (raen && init_done_q) begin
                    ridx_d = raddr[ADDR_BITS+1:2];
                    rcnt_d = LAT;
                    rst_d  = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rcnt_q == '0) begin
                    rdata_d = rd_word;
                    rst_d   = R_DATA;
                end else begin
                    rcnt_d = rcnt_q - 4'd1;
                end
            end
            R_DATA: begin
                if (rden) rst_d = R_IDLE;
            end
            default: rst_d = R_IDLE;
        endcase
    end

    // Control state registers; reset abandons any access in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wst_q       <= W_IDLE;
            wcnt_q      <= '0;
            widx_q      <= '0;
            rst_q       <= R_IDLE;
            rcnt_q      <= '0;
            ridx_q      <= '0;
            rdata_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            wst_q       <= wst_d;
            wcnt_q      <= wcnt_d;
            widx_q      <= widx_d;
            rst_q       <= rst_d;
            rcnt_q      <= rcnt_d;
            ridx_q      <= ridx_d;
            rdata_q     <= rdata_d;
            init_done_q <= init_done_d;
        end
    end

    // Outputs decode registered state only.
    assign wardy     = (wst_q == W_IDLE) && init_done_q;
    assign wdrdy     = (wst_q == W_DATA);
    assign wbvld     = (wst_q == W_RESP);
    assign rardy     = (rst_q == R_IDLE) && init_done_q;
    assign rdrdy     = (rst_q == R_DATA);
    assign rdata     = rdata_q;
    assign init_done = init_done_q;
endmodule

// File: tb/tb_ext_mem_resp.sv
// tb_ext_mem_resp: randomized and directed stimulus against a cycle-level behavioural model.
// Latency: checks every output every cycle on the falling edge.
// Backpressure: exercises held read data, same-edge write/read collision and mid-access reset.
module tb_ext_mem_resp;
    localparam int AB = 12;
    localparam int L  = 2;
    localparam int N  = 1 << AB;
`ifdef EXT_MEM_CLEAR_EN
    localparam bit CLR    = 1'b1;
    localparam int INIT_C = N;
`else
    localparam bit CLR    = 1'b0;
    localparam int INIT_C = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        waen = 1'b0, wden = 1'b0, raen = 1'b0, rden = 1'b0;
    logic [31:0] waddr = '0, wdata = '0, raddr = '0;
    logic [3:0]  wmask = '0;
    logic        wardy, wdrdy, wbvld, rardy, rdrdy, init_done;
    logic [31:0] rdata;

    always #5 clock = ~clock;

    ext_mem_resp #(.ADDR_BITS(AB), .LATENCY(L)) dut (
        .clock(clock), .reset(reset),
        .waen(waen), .waddr(waddr), .wardy(wardy),
        .wden(wden), .wdata(wdata), .wmask(wmask), .wdrdy(wdrdy),
        .wbvld(wbvld),
        .raen(raen), .raddr(raddr), .rardy(rardy),
        .rden(rden), .rdata(rdata), .rdrdy(rdrdy),
        .init_done(init_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] k);
        return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) & 32'(N - 1));
    endfunction

    // Behavioural model: memory image with per-byte "known" flags, plus per-direction phase and due cycles.
    logic [31:0] mem_m [int];
    logic [3:0]  kn_m  [int];
    int          cyc = -1;
    int          w_st = 0, r_st = 0;
    int          widx_m = 0, ridx_m = 0, wb_c = 0, ld_c = 0;
    logic [31:0] exp_rd = '0;
    logic [3:0]  exp_kn = 4'hF;
    logic        e_init, e_wa, e_wd, e_wb, e_ra, e_rd;
    logic [31:0] mv;
    logic [3:0]  mk;

    always @(negedge clock) begin
        if (!reset) begin
            chk("reset_ctrl", {26'b0, wardy, wdrdy, wbvld, rardy, rdrdy, init_done}, 32'h0);
            chk("reset_rdata", rdata, 32'h0);
            cyc = -1; w_st = 0; r_st = 0;
            exp_rd = '0; exp_kn = 4'hF;
            if (CLR) begin
                mem_m.delete();
                kn_m.delete();
            end
        end else begin
            cyc++;
            e_init = (cyc >= INIT_C);
            e_wa   = e_init && (w_st == 0);
            e_wd   = (w_st == 1);
            e_wb   = (w_st == 2) && (cyc == wb_c);
            e_ra   = e_init && (r_st == 0);
            e_rd   = (r_st == 2);
            chk("init_done", {31'b0, init_done}, {31'b0, e_init});
            chk("wardy", {31'b0, wardy}, {31'b0, e_wa});
            chk("wdrdy", {31'b0, wdrdy}, {31'b0, e_wd});
            chk("wbvld", {31'b0, wbvld}, {31'b0, e_wb});
            chk("rardy", {31'b0, rardy}, {31'b0, e_ra});
            chk("rdrdy", {31'b0, rdrdy}, {31'b0, e_rd});
            chk("rdata", rdata & bmask(exp_kn), exp_rd & bmask(exp_kn));
            // write side first so a same-edge read load sees the committed bytes
            case (w_st)
                0: if (e_wa && waen) begin widx_m = idx_of(waddr); w_st = 1; end
                1: if (wden) begin
                    mv = mem_m.exists(widx_m) ? mem_m[widx_m] : 32'h0;
                    mk = kn_m.exists(widx_m) ? kn_m[widx_m] : (CLR ? 4'hF : 4'h0);
                    for (int b = 0; b < 4; b++) begin
                        if (wmask[b]) begin
                            mv[8*b +: 8] = wdata[8*b +: 8];
                            mk[b] = 1'b1;
                        end
                    end
                    mem_m[widx_m] = mv;
                    kn_m[widx_m]  = mk;
                    wb_c = cyc + L + 2;
                    w_st = 2;
                end
                default: if (cyc == wb_c) w_st = 0;
            endcase
            case (r_st)
                0: if (e_ra && raen) begin ridx_m = idx_of(raddr); ld_c = cyc + L + 1; r_st = 1; end
                1: if (cyc == ld_c) begin
                    exp_rd = mem_m.exists(ridx_m) ? mem_m[ridx_m] : 32'h0;
                    exp_kn = kn_m.exists(ridx_m) ? kn_m[ridx_m] : (CLR ? 4'hF : 4'h0);
                    r_st = 2;
                end
                default: if (rden) r_st = 0;
            endcase
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int k; bit ok;
        @(posedge clock); #1; waen = 1'b1; waddr = a;
        ok = 0;
        for (int i = 0; i < 200; i++) begin @(negedge clock); if (wardy) begin ok = 1; break; end end
        if (!ok) chk("wr_addr_timeout", 32'h0, 32'h1);
        @(posedge clock); #1; waen = 1'b0; wden = 1'b1; wdata = d; wmask = m;
        ok = 0;
        for (int i = 0; i < 200; i++) begin @(negedge clock); if (wdrdy) begin ok = 1; break; end end
        if (!ok) chk("wr_data_timeout", 32'h0, 32'h1);
        @(posedge clock); #1; wden = 1'b0;
        k = 0;
        for (int i = 1; i <= 60; i++) begin @(negedge clock); if (wbvld) begin k = i; break; end end
        chk("wb_latency", 32'(k), 32'(L + 2));
    endtask

    task automatic rd_data(input logic [31:0] e, input int hold);
        int k;
        k = 0;
        for (int i = 1; i <= 60; i++) begin @(negedge clock); if (rdrdy) begin k = i; break; end end
        chk("rd_latency", 32'(k), 32'(L + 2));
        chk("rd_value", rdata, e);
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk("bp_rdrdy", {31'b0, rdrdy}, 32'h1);
            chk("bp_rardy", {31'b0, rardy}, 32'h0);
            chk("bp_rdata", rdata, e);
        end
        @(posedge clock); #1; rden = 1'b1;
        @(posedge clock); #1; rden = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input int hold);
        bit ok;
        @(posedge clock); #1; raen = 1'b1; raddr = a;
        ok = 0;
        for (int i = 0; i < 200; i++) begin @(negedge clock); if (rardy) begin ok = 1; break; end end
        if (!ok) chk("rd_addr_timeout", 32'h0, 32'h1);
        @(posedge clock); #1; raen = 1'b0;
        rd_data(e, hold);
    endtask

    task automatic wait_init();
        bit ok;
        ok = 0;
        for (int i = 0; i < 6000; i++) begin @(negedge clock); if (init_done) begin ok = 1; break; end end
        if (!ok) chk("init_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        int k; bit ok;
        // reset, with raen held high so the clear sweep blocks it
        raen = CLR; raddr = 32'h100;
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        if (CLR) begin
            k = 0; ok = 0;
            for (int i = 0; i < 6000; i++) begin
                @(negedge clock);
                if (rardy) begin ok = 1; break; end
                k++;
            end
            chk("clear_rardy_low_cycles", 32'(k), 32'd4096);
            chk("clear_init_done", {31'b0, init_done}, 32'h1);
            @(posedge clock); #1; raen = 1'b0;
            rd_data(32'h0000_0000, 0);
        end else begin
            @(negedge clock); chk("init_cycle0", {31'b0, init_done}, 32'h0);
            @(negedge clock); chk("init_cycle1", {31'b0, init_done}, 32'h1);
        end

        wr(32'h10, 32'hDEADBEEF, 4'hF);
        rd(32'h10, 32'hDEADBEEF, 0);
        wr(32'h10, 32'h11223344, 4'h5);
        rd(32'h10, 32'hDE22BE44, 0);
        wr(32'h0000_4010, 32'hCAFEF00D, 4'hF);
        rd(32'h0000_0010, 32'hCAFEF00D, 0);

        // collision: write data commits on the same edge the read loads rdata
        wr(32'h20, 32'h0, 4'hF);
        @(posedge clock); #1; waen = 1'b1; waddr = 32'h20;
        ok = 0;
        for (int i = 0; i < 200; i++) begin @(negedge clock); if (wardy) begin ok = 1; break; end end
        if (!ok) chk("col_waddr_timeout", 32'h0, 32'h1);
        @(posedge clock); #1; waen = 1'b0; raen = 1'b1; raddr = 32'h20;
        ok = 0;
        for (int i = 0; i < 200; i++) begin @(negedge clock); if (rardy) begin ok = 1; break; end end
        if (!ok) chk("col_raddr_timeout", 32'h0, 32'h1);
        @(posedge clock); #1; raen = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1; wden = 1'b1; wdata = 32'hA5A5A5A5; wmask = 4'h3;
        @(posedge clock); #1; wden = 1'b0;
        @(negedge clock);
        chk("col_rdrdy", {31'b0, rdrdy}, 32'h1);
        chk("col_rdata", rdata, 32'h0000A5A5);
        for (int h = 0; h < 10; h++) begin
            @(negedge clock);
            chk("col_hold_rdata", rdata, 32'h0000A5A5);
            chk("col_hold_rardy", {31'b0, rardy}, 32'h0);
        end
        @(posedge clock); #1; rden = 1'b1;
        @(posedge clock); #1; rden = 1'b0;
        repeat (8) @(posedge clock);

        // reset while the write is in its wait phase
        #1 waen = 1'b1; waddr = 32'h30;
        ok = 0;
        for (int i = 0; i < 200; i++) begin @(negedge clock); if (wardy) begin ok = 1; break; end end
        if (!ok) chk("mr_waddr_timeout", 32'h0, 32'h1);
        @(posedge clock); #1; waen = 1'b0; wden = 1'b1; wdata = 32'h12345678; wmask = 4'hF;
        ok = 0;
        for (int i = 0; i < 200; i++) begin @(negedge clock); if (wdrdy) begin ok = 1; break; end end
        if (!ok) chk("mr_wdata_timeout", 32'h0, 32'h1);
        @(posedge clock); #1; wden = 1'b0;
        @(negedge clock); #1; reset = 1'b0;
        #1;
        chk("mid_reset_ctrl", {26'b0, wardy, wdrdy, wbvld, rardy, rdrdy, init_done}, 32'h0);
        chk("mid_reset_rdata", rdata, 32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("no_wbvld_after_reset", {31'b0, wbvld}, 32'h0);
        end
        wait_init();

        // randomized traffic on a few indices with random upper address bits
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock); #1;
            waen  = 1'($urandom_range(0, 1));
            waddr = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 7)) << 2);
            wden  = 1'($urandom_range(0, 1));
            wdata = $urandom;
            wmask = 4'($urandom);
            raen  = 1'($urandom_range(0, 1));
            raddr = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 7)) << 2);
            rden  = ($urandom_range(0, 3) != 0);
        end
        @(posedge clock); #1;
        waen = 1'b0; wden = 1'b0; raen = 1'b0; rden = 1'b1;
        repeat (30) @(posedge clock);
        #1 rden = 1'b0;
        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ext_mem_resp.md
EXT_MEM_RESP -- requirements
Module: ext_mem_resp

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, giving the word-index width; the memory is 2^ADDR_BITS 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, giving extra wait cycles per access; legal range 0..15.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports waen in 1, waddr in 32 and wardy out 1: write-address channel; transfer when waen&&wardy.
REQ-006 SHALL have ports wden in 1, wdata in 32, wmask in 4 and wdrdy out 1: write-data channel; transfer when wden&&wdrdy; wmask[i] enables byte i.
REQ-007 SHALL have port wbvld, out 1: a one-cycle write-complete pulse; the channel has no ready.
REQ-008 SHALL have ports raen in 1, raddr in 32 and rardy out 1: read-address channel; transfer when raen&&rardy.
REQ-009 SHALL have ports rden in 1, rdata out 32 and rdrdy out 1: read-data channel; rdrdy=valid, rden=ready; transfer when rden&&rdrdy.
REQ-010 SHALL have port init_done, out 1: memory usable; stays high until next reset.

Function
REQ-011 SHALL form the word index from addr[ADDR_BITS+1:2]; addr[1:0] and upper bits are ignored, so out-of-range addresses wrap.
REQ-012 SHALL decode every output from registered state only, with no combinational input-to-output path.
REQ-013 Write FSM SHALL be W_IDLE(wardy=init_done) -> addr transfer, latch index -> W_DATA(wdrdy=1) -> data transfer, commit masked bytes on that edge, cnt=LATENCY -> W_WAIT(cnt==0 ? W_RESP : cnt-1) -> W_RESP(wbvld=1) -> W_IDLE.
REQ-014 SHALL assert wbvld exactly in cycle t+LATENCY+2 for a data transfer in cycle t.
REQ-015 SHALL keep wdrdy low in W_IDLE, so data presented before the address is not taken.
REQ-016 Read FSM SHALL be R_IDLE(rardy=init_done) -> addr transfer, latch index, cnt=LATENCY -> R_WAIT(cnt==0 ? load rdata, R_DATA : cnt-1) -> R_DATA(rdrdy=1) -> rden -> R_IDLE.
REQ-017 SHALL make rdrdy first high in cycle t+LATENCY+2 for an address transfer in cycle t.
REQ-018 SHALL hold rdata and rdrdy stable while rden is low, with no timeout.
REQ-019 SHALL run the read and write FSMs independently and concurrently, with one outstanding access per direction.
REQ-020 SHALL load new bytes into rdata (byte-wise bypass per wmask, same index) when a write commit and an rdata load fall on the same edge.
REQ-021 SHALL keep wardy, rardy, wdrdy and rdrdy low while init_done is low.

Reset
REQ-022 SHALL drive, while reset is low: wardy=0, wdrdy=0, wbvld=0, rardy=0, rdrdy=0, rdata=0, init_done=0; FSMs at W_IDLE/R_IDLE; cnt=0.
REQ-023 SHALL abandon any access in flight when reset is asserted mid-operation, with no wbvld or rdrdy afterwards for it.
REQ-024 SHALL NOT reset memory contents, except via REQ-025.

Configuration
REQ-025 With EXT_MEM_CLEAR_EN defined, SHALL run a clear sweep after reset release: one word zeroed per cycle, index 0 to 2^ADDR_BITS-1; init_done rises the cycle after the last word.
REQ-026 Without EXT_MEM_CLEAR_EN, SHALL omit the sweep counter; init_done rises on the first edge after reset release; contents are undefined until written.

Verification (ADDR_BITS=12, LATENCY=2)
REQ-027 Clear: EXT_MEM_CLEAR_EN set, release reset, raen held high from release -> rardy=0 for 4096 cycles, then init_done=1; read 0x100 returns 0x00000000.
REQ-028 Full write/read: write 0x10 = 0xDEADBEEF, mask 0xF, data at cycle t -> wbvld one cycle at t+4; read 0x10 at cycle u -> rdrdy at u+4, rdata 0xDEADBEEF.
REQ-029 Partial mask: write 0x10 = 0x11223344, mask 0x5, onto 0xDEADBEEF -> read 0x10 returns 0xDE22BE44.
REQ-030 Wrap: write 0x00004010 = 0xCAFEF00D -> read 0x00000010 returns 0xCAFEF00D.
REQ-031 Backpressure and collision: rden low for 10 cycles in R_DATA -> rdata/rdrdy stable, rardy=0; same-edge write 0xA5A5A5A5 mask 0x3 to a word holding 0 -> rdata 0x0000A5A5.
REQ-032 Reset mid-write: assert reset in W_WAIT -> all outputs 0 at once; no wbvld after release.
